dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port 128-word data memory between two requesters: the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
- CPU has fixed priority. A starvation counter forces one EXT grant after MAX_WAIT consecutive denied cycles.
- Drives the memory's synchronous port and returns read data with 1-cycle latency.
- Asserts cpu_stall so the pipeline freezes the MEM stage while it is denied.

Parameters:
- ADDR_W, 7, word-address width (128 words).
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied EXT cycles before a forced EXT grant; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  load data valid (cycle after granted load)
- cpu_rdata  out  DATA_W  load data
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: same semantics for the EXT port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read strobe

Behaviour:
- States: NORMAL and FORCE_EXT. Registers: state, wait_cnt[3:0], rd_owner (none/CPU/EXT).
- Reset (rst=1 at posedge):
  - state=NORMAL, wait_cnt=0, rd_owner=none.
  - cpu_gnt, ext_gnt, mem_en, mem_we, cpu_rvalid, ext_rvalid all 0.
  - mem_addr, mem_wdata, cpu_rdata, ext_rdata all 0.
  - While rst is high, all grants are forced to 0.
- Grant logic is combinational from state and requests:
  - NORMAL: cpu_gnt=cpu_req; ext_gnt=ext_req & ~cpu_req.
  - FORCE_EXT: ext_gnt=ext_req; cpu_gnt=cpu_req & ~ext_req.
- Memory drive (combinational from the winner):
  - mem_en = cpu_gnt | ext_gnt.
  - mem_we, mem_addr, mem_wdata are muxed from the winner.
  - All four are 0 when there is no winner.
- wait_cnt:
  - Increments when ext_req & ~ext_gnt.
  - Clears when ext_gnt or ~ext_req.
  - Saturates at MAX_WAIT.
- Transitions:
  - NORMAL -> FORCE_EXT when the increment makes wait_cnt reach MAX_WAIT.
  - FORCE_EXT -> NORMAL on ext_gnt, or when ext_req drops (wait_cnt cleared).
- Read return:
  - A granted load (gnt & ~we) sets rd_owner for the next cycle.
  - The owner's rvalid=1 for exactly 1 cycle, with rdata=mem_rdata.
  - The non-owner's rdata holds 0.
  - Stores produce no rvalid.
- Back-to-back grants to either port are allowed every cycle; throughput is 1 access/cycle.
- Simultaneous requests in NORMAL: CPU wins and EXT waits.
- Reset mid-operation: a pending rvalid is dropped and no memory strobe is issued during rst.
- Requesters must hold req/we/addr/wdata stable until granted. A request dropped before grant is simply withdrawn.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three extra output ports are added:
  - stat_cpu_stall  32 bits: cycles with cpu_stall=1.
  - stat_ext_gnt  32 bits: EXT grants.
  - stat_force  32 bits: NORMAL->FORCE_EXT transitions.
- All counters are cleared by rst and saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Reset, then CPU store addr 5 = 0xDEADBEEF, then CPU load addr 5 -> cpu_gnt=1 both cycles, cpu_rvalid=1 the cycle after the load, cpu_rdata=0xDEADBEEF, ext_rvalid=0.
- EXT only: store addr 127 = 0x12345678, then load addr 127 -> ext_gnt immediate, ext_rdata=0x12345678 one cycle later.
- CPU and EXT both request continuously, MAX_WAIT=4 -> CPU granted 4 cycles, 5th cycle ext_gnt=1 with cpu_stall=1, then CPU resumes; the pattern repeats every 5 cycles.
- Starving EXT drops ext_req at wait_cnt=3 -> state stays NORMAL, wait_cnt=0, no forced grant.
- Assert rst in the cycle after a granted CPU load -> cpu_rvalid=0 the next cycle, all outputs 0, state NORMAL.
- With DMEM_ARB_STATS_EN, run scenario 3 for 20 cycles -> stat_force=4, stat_ext_gnt=4, stat_cpu_stall=4.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU/EXT arbiter for the single-port data memory, with a
// starvation counter that forces one EXT grant. Optional counters: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state,
    output logic [3:0]        dbg_wait_cnt
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_stall,
    output logic [31:0]       stat_ext_gnt,
    output logic [31:0]       stat_force
`endif
);

    // Handshake: req/we/addr/wdata are held by the requester until gnt is seen
    // high in a cycle; that cycle is the access. Loads return rvalid one cycle later.
    typedef enum logic {NORMAL = 1'b0, FORCE_EXT = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_EXT = 2'd2} owner_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    owner_t     rd_owner, rd_owner_nxt;

    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!rst) begin
            if (state == FORCE_EXT) begin
                ext_gnt = ext_req;
                cpu_gnt = cpu_req & ~ext_req;
            end else begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_req & ~cpu_req;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = 4'd0;
        rd_owner_nxt = OWN_NONE;
        if (ext_req && !ext_gnt)
            wait_cnt_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 4'd1;
        case (state)
            NORMAL:    if (ext_req && !ext_gnt && wait_cnt_nxt == WAIT_MAX) state_nxt = FORCE_EXT;
            FORCE_EXT: if (ext_gnt || !ext_req) state_nxt = NORMAL;
        endcase
        if (cpu_gnt && !cpu_we)
            rd_owner_nxt = OWN_CPU;
        else if (ext_gnt && !ext_we)
            rd_owner_nxt = OWN_EXT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
            rd_owner <= OWN_NONE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    // rvalid is gated by rst so a load in flight when reset arrives is dropped.
    assign cpu_rvalid = !rst && (rd_owner == OWN_CPU);
    assign ext_rvalid = !rst && (rd_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cpu_stall <= 32'd0;
            stat_ext_gnt   <= 32'd0;
            stat_force     <= 32'd0;
        end else begin
            if (cpu_stall && stat_cpu_stall != 32'hFFFF_FFFF)
                stat_cpu_stall <= stat_cpu_stall + 32'd1;
            if (ext_gnt && stat_ext_gnt != 32'hFFFF_FFFF)
                stat_ext_gnt <= stat_ext_gnt + 32'd1;
            if (state == NORMAL && state_nxt == FORCE_EXT && stat_force != 32'hFFFF_FFFF)
                stat_force <= stat_force + 32'd1;
        end
    end
`endif

endmodule
